ball_motion: RTL and testbench



---
 rtl/ball_motion.sv | 220 ++++++++++++++++++++++
 tb/tb_ball_motion.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// Ball kinematics and serve/run/die/over sequencing for the breakout game loop.
// Latency: position/direction registered, updated 1 clk after each movement tick.
// Backpressure: none; collision flags are sampled every clk, RUN-phase flags are latched until the next tick.
//
// Ports:
//   clk, rst       system clock, asynchronous active-low reset
//   iStart         launch request (level; rising edge serves the ball from IDLE)
//   iLevel         speed select, step = iLevel+1 px/tick, level 3 saturates to 3 px
//   iCrash         {left, right, up, down} collision flags from crash detection
//   iBallDie       ball fell below the bottom edge
//   oBall_x/_y     ball centre, fed back to crash detection and the renderer
//   oDir           {dx_neg, dy_neg}, 1 = coordinate decreasing
//   oState         0 IDLE, 1 RUN, 2 DIE, 3 OVER
//   oLives         remaining lives
//   oGameOver      high while in OVER
module ball_motion #(
    parameter int TICK_DIV   = 250000,
    parameter int START_X    = 320,
    parameter int START_Y    = 400,
    parameter int LIVES_INIT = 3,
    parameter int DIE_TICKS  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iStart,
    input  logic [1:0] iLevel,
    input  logic [3:0] iCrash,
    input  logic       iBallDie,
    output logic [9:0] oBall_x,
    output logic [9:0] oBall_y,
    output logic [1:0] oDir,
    output logic [1:0] oState,
    output logic [1:0] oLives,
    output logic       oGameOver
);

    // 640x480 screen, ball radius 10: centre must stay within [10, 629] x [10, 469].
    localparam logic [9:0] X_MIN = 10'd10;
    localparam logic [9:0] X_MAX = 10'd629;
    localparam logic [9:0] Y_MIN = 10'd10;
    localparam logic [9:0] Y_MAX = 10'd469;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DIE_TICKS > 1) ? $clog2(DIE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIE_LAST  = DW'(DIE_TICKS - 1);

    localparam logic [9:0] SERVE_X = 10'(START_X);
    localparam logic [9:0] SERVE_Y = 10'(START_Y);
    localparam logic [1:0] LIVES_0 = 2'(LIVES_INIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DIE  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t        r_state,   w_state_nxt;
    logic [9:0]    r_x,       w_x_nxt;
    logic [9:0]    r_y,       w_y_nxt;
    logic          r_dx_neg,  w_dx_neg_nxt;
    logic          r_dy_neg,  w_dy_neg_nxt;
    logic [1:0]    r_lives,   w_lives_nxt;
    logic [3:0]    r_pend,    w_pend_nxt;
    logic [DW-1:0] r_die_cnt, w_die_cnt_nxt;
    logic [TW-1:0] r_tick_cnt;
    logic          r_start_q;

    logic          w_tick;
    logic          w_start_rise;
    logic [3:0]    w_eff;
    logic [1:0]    w_step;
    logic          w_dx_new;
    logic          w_dy_new;
    logic [9:0]    w_x_mv;
    logic [9:0]    w_y_mv;

    // Move one axis by step in 11-bit signed space, then clamp to the play field.
    function automatic logic [9:0] f_move(input logic [9:0] pos, input logic neg,
                                          input logic [1:0] step,
                                          input logic [9:0] lo, input logic [9:0] hi);
        logic signed [10:0] s;
        s = $signed({1'b0, pos});
        if (neg) s = s - $signed({9'd0, step});
        else     s = s + $signed({9'd0, step});
        if (s < $signed({1'b0, lo}))      f_move = lo;
        else if (s > $signed({1'b0, hi})) f_move = hi;
        else                              f_move = s[9:0];
    endfunction

    // Free-running movement tick, independent of state.
    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_start_q  <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_start_q  <= iStart;
        end
    end

    assign w_start_rise = iStart & ~r_start_q;

    // Flags seen during the tick cycle itself are merged with the latched ones.
    assign w_eff  = r_pend | iCrash;
    assign w_step = (iLevel == 2'd3) ? 2'd3 : (iLevel + 2'd1);

    // Horizontal: left pushes right, right pushes left, both toggles.
    always_comb begin
        w_dx_new = r_dx_neg;
        case (w_eff[3:2])
            2'b10:   w_dx_new = 1'b0;
            2'b01:   w_dx_new = 1'b1;
            2'b11:   w_dx_new = ~r_dx_neg;
            default: w_dx_new = r_dx_neg;
        endcase
    end

    // Vertical: up pushes down, down pushes up, both toggles.
    always_comb begin
        w_dy_new = r_dy_neg;
        case (w_eff[1:0])
            2'b10:   w_dy_new = 1'b0;
            2'b01:   w_dy_new = 1'b1;
            2'b11:   w_dy_new = ~r_dy_neg;
            default: w_dy_new = r_dy_neg;
        endcase
    end

    // The move always uses the direction just resolved on this tick.
    assign w_x_mv = f_move(r_x, w_dx_new, w_step, X_MIN, X_MAX);
    assign w_y_mv = f_move(r_y, w_dy_new, w_step, Y_MIN, Y_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_dx_neg_nxt  = r_dx_neg;
        w_dy_neg_nxt  = r_dy_neg;
        w_lives_nxt   = r_lives;
        w_pend_nxt    = r_pend;
        w_die_cnt_nxt = r_die_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start_rise) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                // Death takes priority over a coincident tick: no move that cycle.
                if (iBallDie) begin
                    w_state_nxt   = S_DIE;
                    w_lives_nxt   = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                    w_pend_nxt    = 4'd0;
                    w_die_cnt_nxt = '0;
                end else if (w_tick) begin
                    w_dx_neg_nxt = w_dx_new;
                    w_dy_neg_nxt = w_dy_new;
                    w_x_nxt      = w_x_mv;
                    w_y_nxt      = w_y_mv;
                    w_pend_nxt   = 4'd0;
                end else begin
                    w_pend_nxt = r_pend | iCrash;
                end
            end
            S_DIE: begin
                if (w_tick) begin
                    if (r_die_cnt == DIE_LAST) begin
                        if (r_lives == 2'd0) begin
                            w_state_nxt = S_OVER;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_x_nxt      = SERVE_X;
                            w_y_nxt      = SERVE_Y;
                            w_dx_neg_nxt = 1'b0;
                            w_dy_neg_nxt = 1'b1;
                        end
                    end else begin
                        w_die_cnt_nxt = r_die_cnt + DW'(1);
                    end
                end
            end
            S_OVER: begin
                w_state_nxt = S_OVER;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_x       <= SERVE_X;
            r_y       <= SERVE_Y;
            r_dx_neg  <= 1'b0;
            r_dy_neg  <= 1'b1;
            r_lives   <= LIVES_0;
            r_pend    <= 4'd0;
            r_die_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_dx_neg  <= w_dx_neg_nxt;
            r_dy_neg  <= w_dy_neg_nxt;
            r_lives   <= w_lives_nxt;
            r_pend    <= w_pend_nxt;
            r_die_cnt <= w_die_cnt_nxt;
        end
    end

    assign oBall_x   = r_x;
    assign oBall_y   = r_y;
    assign oDir      = {r_dx_neg, r_dy_neg};
    assign oState    = r_state;
    assign oLives    = r_lives;
    assign oGameOver = (r_state == S_OVER);

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed serve/crash/clamp/lives/reset scenarios with
// literal expectations, plus randomized play checked every cycle against a model.
// Fast tick (4 clk) so full games fit in a short run.
module tb_ball_motion;

    localparam int TD = 4;
    localparam int DT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iStart = 1'b0;
    logic [1:0] iLevel = 2'd0;
    logic [3:0] iCrash = 4'd0;
    logic       iBallDie = 1'b0;
    logic [9:0] oBall_x, oBall_y;
    logic [1:0] oDir, oState, oLives;
    logic       oGameOver;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model state (plain integers).
    int m_x, m_y, m_dxn, m_dyn, m_state, m_lives, m_pend, m_prev, m_cyc, m_dtk;

    ball_motion #(
        .TICK_DIV(TD), .START_X(320), .START_Y(400), .LIVES_INIT(3), .DIE_TICKS(DT)
    ) dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iLevel(iLevel), .iCrash(iCrash),
        .iBallDie(iBallDie), .oBall_x(oBall_x), .oBall_y(oBall_y), .oDir(oDir),
        .oState(oState), .oLives(oLives), .oGameOver(oGameOver)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic m_reset();
        m_x = 320; m_y = 400; m_dxn = 0; m_dyn = 1;
        m_state = 0; m_lives = 3; m_pend = 0; m_prev = 0; m_cyc = 0; m_dtk = 0;
    endtask

    // One clock of game rules.
    task automatic m_step();
        bit tick, rise;
        int eff, step, l, r, u, d;
        tick  = (m_cyc % TD) == (TD - 1);
        m_cyc = m_cyc + 1;
        rise  = iStart && (m_prev == 0);
        m_prev = int'(iStart);
        case (m_state)
            0: if (rise) m_state = 1;
            1: begin
                if (iBallDie) begin
                    m_state = 2;
                    if (m_lives > 0) m_lives = m_lives - 1;
                    m_pend = 0;
                    m_dtk  = 0;
                end else if (tick) begin
                    eff = m_pend | int'(iCrash);
                    l = (eff >> 3) & 1; r = (eff >> 2) & 1;
                    u = (eff >> 1) & 1; d = eff & 1;
                    if (l != 0 && r == 0)      m_dxn = 0;
                    else if (r != 0 && l == 0) m_dxn = 1;
                    else if (l != 0 && r != 0) m_dxn = 1 - m_dxn;
                    if (u != 0 && d == 0)      m_dyn = 0;
                    else if (d != 0 && u == 0) m_dyn = 1;
                    else if (u != 0 && d != 0) m_dyn = 1 - m_dyn;
                    step = (int'(iLevel) + 1 > 3) ? 3 : int'(iLevel) + 1;
                    m_x = clampi((m_dxn != 0) ? m_x - step : m_x + step, 10, 629);
                    m_y = clampi((m_dyn != 0) ? m_y - step : m_y + step, 10, 469);
                    m_pend = 0;
                end else begin
                    m_pend = m_pend | int'(iCrash);
                end
            end
            2: if (tick) begin
                m_dtk = m_dtk + 1;
                if (m_dtk == DT) begin
                    if (m_lives == 0) m_state = 3;
                    else begin
                        m_state = 0; m_x = 320; m_y = 400; m_dxn = 0; m_dyn = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else      m_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && cmp_en) begin
                check("cyc_x",     oBall_x,   m_x);
                check("cyc_y",     oBall_y,   m_y);
                check("cyc_dir",   oDir,      m_dxn * 2 + m_dyn);
                check("cyc_state", oState,    m_state);
                check("cyc_lives", oLives,    m_lives);
                check("cyc_over",  oGameOver, (m_state == 3) ? 1 : 0);
            end
        end
    end

    task automatic wait_move(input string nm);
        logic [9:0] px, py;
        int n;
        px = oBall_x; py = oBall_y; n = 0;
        while (oBall_x == px && oBall_y == py && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (oBall_x == px && oBall_y == py) begin
            n_chk++; n_fail++;
            $display("FAIL %s: ball did not move within 40 cycles, x=%0d y=%0d", nm, oBall_x, oBall_y);
        end
    endtask

    task automatic wait_state(input string nm, input logic [1:0] tgt, input int budget);
        int n;
        n = 0;
        while (oState !== tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(nm, oState, tgt);
    endtask

    task automatic pulse_start();
        @(negedge clk); iStart = 1'b1;
        @(negedge clk); iStart = 1'b0;
    endtask

    task automatic pulse_die();
        @(negedge clk); iBallDie = 1'b1;
        @(negedge clk); iBallDie = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Crash pulse right after a move (never on a tick cycle), then check the next move.
    task automatic crash_step(input logic [3:0] c, input int ex, input int ey, input int ed);
        iCrash = c;
        @(negedge clk);
        iCrash = 4'd0;
        wait_move("crash_move");
        check("crash_x", oBall_x, ex);
        check("crash_y", oBall_y, ey);
        check("crash_dir", oDir, ed);
    endtask

    task automatic check_serve_pos(input string nm);
        check({nm, "_x"}, oBall_x, 320);
        check({nm, "_y"}, oBall_y, 400);
        check({nm, "_dir"}, oDir, 1);
    endtask

    initial begin
        // Reset values while reset is held.
        #23;
        check_serve_pos("rst");
        check("rst_state", oState, 0);
        check("rst_lives", oLives, 3);
        check("rst_over", oGameOver, 0);
        @(negedge clk);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Serve at level 0.
        pulse_start();
        check("serve_state", oState, 1);
        wait_move("serve");
        check("serve_x", oBall_x, 321);
        check("serve_y", oBall_y, 399);
        check("serve_dir", oDir, 1);
        check("serve_state_run", oState, 1);

        // Latched crash flags and simultaneous-flag toggling.
        crash_step(4'b0010, 322, 400, 0);
        crash_step(4'b0001, 323, 399, 1);
        crash_step(4'b0010, 324, 400, 0);
        crash_step(4'b1100, 323, 401, 2);
        crash_step(4'b0001, 322, 400, 3);
        crash_step(4'b1010, 323, 401, 0);

        // Crash presented exactly on the tick cycle must still act.
        repeat (3) @(negedge clk);
        iCrash = 4'b0001;
        @(negedge clk);
        iCrash = 4'd0;
        check("tickcrash_x", oBall_x, 324);
        check("tickcrash_y", oBall_y, 400);
        check("tickcrash_dir", oDir, 1);

        // Clamp at the right edge: steer to x=628, then a 3 px step lands on 629.
        iLevel = 2'd3;
        while (oBall_x < 625) wait_move("to_edge");
        iLevel = 2'(628 - int'(oBall_x) - 1);
        wait_move("to_628");
        check("edge_628", oBall_x, 628);
        iLevel = 2'd3;
        wait_move("clamp");
        check("clamp_x", oBall_x, 629);
        repeat (TD * 40) @(negedge clk);
        check("clamp_x_hold", oBall_x, 629);
        check("clamp_y_top", oBall_y, 10);

        // Randomized play against the model.
        for (int seg = 0; seg < 2; seg++) begin
            do_reset();
            iLevel = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk);
                iCrash   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                if ($urandom_range(0, 99) == 0) iLevel = 2'($urandom_range(0, 3));
                iBallDie = ($urandom_range(0, 399) == 0);
                iStart   = ($urandom_range(0, 9) == 0);
            end
            @(negedge clk);
            iCrash = 4'd0; iBallDie = 1'b0; iStart = 1'b0;
        end

        // Lives: three deaths lead to OVER, which ignores iStart.
        do_reset();
        iLevel = 2'd1;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clk);
            pulse_die();
            check("die_state", oState, 2);
            check("die_lives", oLives, 2 - k);
            if (k < 2) begin
                wait_state("reserve_idle", 2'd0, DT * TD + 20);
                check_serve_pos("reserve");
                pulse_start();
                check("relaunch", oState, 1);
            end else begin
                wait_state("over_state", 2'd3, DT * TD + 20);
                check("over_flag", oGameOver, 1);
                check("over_lives", oLives, 0);
                pulse_start();
                repeat (TD * 3) @(negedge clk);
                check("over_sticky", oState, 3);
            end
        end

        // Asynchronous reset between clock edges in the middle of DIE.
        do_reset();
        pulse_start();
        repeat (12) @(negedge clk);
        pulse_die();
        check("pre_arst_lives", oLives, 2);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_serve_pos("arst");
        check("arst_state", oState, 0);
        check("arst_lives", oLives, 3);
        check("arst_over", oGameOver, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
